output_layer_sequencer: RTL and testbench

Sequencer and accumulator for the network's output layer. It steps the hidden-neuron index over all hidden neurons and drives that index as `hid_sel` to both the output weight memory's select input and the hidden-activation buffer. Each cycle it takes the ten combinationally returned weights and the selected activation and multiply-accumulates them into ten class scores. Optionally it then picks the winning class.

---
 rtl/nn_pkg.sv | 28 ++
 rtl/output_mac_lane.sv | 45 ++++
 rtl/output_layer_sequencer.sv | 170 +++++++++++++++++
 tb/tb_output_layer_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the output-layer datapath.
// The ARGMAX state exists only when OUTPUT_ARGMAX_EN is defined.
package nn_pkg;

    localparam int HIDDEN_N = 20;
    localparam int OUT_N    = 10;
    localparam int ACT_W    = 8;
    localparam int W_W      = 8;
    localparam int ACC_W    = 24;
    // Select width shared with the output weight memory
    localparam int SEL_W    = 32;

`ifdef OUTPUT_ARGMAX_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/output_mac_lane.sv
// One class-score lane: unsigned activation times signed weight, accumulated
// into a sign-extended running score with synchronous clear and enable.
module output_mac_lane #(
    parameter int ACT_W = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [ACT_W-1:0]        act,
    input  logic signed [W_W-1:0]   w,
    output logic signed [ACC_W-1:0] acc
);

    localparam int PROD_W = ACT_W + W_W + 1;

    logic signed [ACT_W:0]      act_s;
    logic signed [PROD_W-1:0]   act_ext;
    logic signed [PROD_W-1:0]   w_ext;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_reg;

    // Activation is unsigned: a zero MSB keeps it positive in signed arithmetic
    assign act_s    = $signed({1'b0, act});
    assign act_ext  = PROD_W'(act_s);
    assign w_ext    = PROD_W'(w);
    assign prod     = act_ext * w_ext;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + prod_ext;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/output_layer_sequencer.sv
// Output-layer sequencer: walks hid_sel over the hidden neurons, drives ten MAC
// lanes and, when OUTPUT_ARGMAX_EN is defined, scans the scores for the winner.
module output_layer_sequencer
    import nn_pkg::*;
#(
    parameter int HIDDEN_N = nn_pkg::HIDDEN_N,
    parameter int ACT_W    = nn_pkg::ACT_W,
    parameter int W_W      = nn_pkg::W_W,
    parameter int ACC_W    = nn_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ACT_W-1:0]        hidden_act,
    input  logic signed [W_W-1:0]   w0,
    input  logic signed [W_W-1:0]   w1,
    input  logic signed [W_W-1:0]   w2,
    input  logic signed [W_W-1:0]   w3,
    input  logic signed [W_W-1:0]   w4,
    input  logic signed [W_W-1:0]   w5,
    input  logic signed [W_W-1:0]   w6,
    input  logic signed [W_W-1:0]   w7,
    input  logic signed [W_W-1:0]   w8,
    input  logic signed [W_W-1:0]   w9,
    output logic [SEL_W-1:0]        hid_sel,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] acc0,
    output logic signed [ACC_W-1:0] acc1,
    output logic signed [ACC_W-1:0] acc2,
    output logic signed [ACC_W-1:0] acc3,
    output logic signed [ACC_W-1:0] acc4,
    output logic signed [ACC_W-1:0] acc5,
    output logic signed [ACC_W-1:0] acc6,
    output logic signed [ACC_W-1:0] acc7,
    output logic signed [ACC_W-1:0] acc8,
    output logic signed [ACC_W-1:0] acc9
`ifdef OUTPUT_ARGMAX_EN
    ,
    output logic [3:0]              class_idx
`endif
);

    logic signed [W_W-1:0]   w_arr   [OUT_N];
    logic signed [ACC_W-1:0] acc_arr [OUT_N];
    state_t                  state_reg;
    logic                    acc_clr;
    logic                    acc_en;
    logic                    last_row;

    assign w_arr[0] = w0;
    assign w_arr[1] = w1;
    assign w_arr[2] = w2;
    assign w_arr[3] = w3;
    assign w_arr[4] = w4;
    assign w_arr[5] = w5;
    assign w_arr[6] = w6;
    assign w_arr[7] = w7;
    assign w_arr[8] = w8;
    assign w_arr[9] = w9;

    assign acc0 = acc_arr[0];
    assign acc1 = acc_arr[1];
    assign acc2 = acc_arr[2];
    assign acc3 = acc_arr[3];
    assign acc4 = acc_arr[4];
    assign acc5 = acc_arr[5];
    assign acc6 = acc_arr[6];
    assign acc7 = acc_arr[7];
    assign acc8 = acc_arr[8];
    assign acc9 = acc_arr[9];

    // Scores are cleared on the accepting edge so they stay readable until then
    assign acc_clr  = (state_reg == ST_IDLE) && start;
    assign acc_en   = (state_reg == ST_ACCUM);
    assign last_row = (hid_sel == SEL_W'(HIDDEN_N - 1));

    generate
        for (genvar gi = 0; gi < OUT_N; gi++) begin : g_lane
            output_mac_lane #(
                .ACT_W (ACT_W),
                .W_W   (W_W),
                .ACC_W (ACC_W)
            ) u_lane (
                .clk (clk),
                .rst (rst),
                .clr (acc_clr),
                .en  (acc_en),
                .act (hidden_act),
                .w   (w_arr[gi]),
                .acc (acc_arr[gi])
            );
        end
    endgenerate

`ifdef OUTPUT_ARGMAX_EN
    logic [3:0] scan_reg;
    logic [3:0] best_reg;
    logic [3:0] best_cand;

    // Strictly-greater compare keeps the lowest index on ties
    always_comb begin
        best_cand = best_reg;
        if (acc_arr[scan_reg] > acc_arr[best_reg]) begin
            best_cand = scan_reg;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            hid_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef OUTPUT_ARGMAX_EN
            scan_reg  <= '0;
            best_reg  <= '0;
            class_idx <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    hid_sel <= '0;
                    if (start) begin
                        state_reg <= ST_ACCUM;
                        busy      <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (last_row) begin
                        hid_sel <= '0;
`ifdef OUTPUT_ARGMAX_EN
                        state_reg <= ST_ARGMAX;
                        best_reg  <= '0;
                        scan_reg  <= 4'd1;
`else
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
`endif
                    end else begin
                        hid_sel <= hid_sel + SEL_W'(1);
                    end
                end
`ifdef OUTPUT_ARGMAX_EN
                ST_ARGMAX: begin
                    best_reg <= best_cand;
                    if (scan_reg == 4'(OUT_N - 1)) begin
                        class_idx <= best_cand;
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        scan_reg <= scan_reg + 4'd1;
                    end
                end
`endif
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer_sequencer.sv
// Directed bench for output_layer_sequencer: combinational weight/activation
// sources keyed by hid_sel, arithmetic reference scores and argmax.
module tb_output_layer_sequencer;

    localparam int N_HID = 20;
    localparam int N_OUT = 10;
`ifdef OUTPUT_ARGMAX_EN
    localparam int LAT = 30;
`else
    localparam int LAT = 21;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         hidden_act;
    logic signed [7:0]  w_drv [N_OUT];
    logic [31:0]        hid_sel;
    logic               busy;
    logic               done;
    logic signed [23:0] acc_v [N_OUT];
    logic [3:0]         class_idx;
    int                 mode_sel = 0;
    int                 vectors = 0;
    int                 fails = 0;

    always #5 clk = ~clk;

`ifndef OUTPUT_ARGMAX_EN
    assign class_idx = 4'd0;
`endif

    output_layer_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hidden_act (hidden_act),
        .w0         (w_drv[0]),
        .w1         (w_drv[1]),
        .w2         (w_drv[2]),
        .w3         (w_drv[3]),
        .w4         (w_drv[4]),
        .w5         (w_drv[5]),
        .w6         (w_drv[6]),
        .w7         (w_drv[7]),
        .w8         (w_drv[8]),
        .w9         (w_drv[9]),
        .hid_sel    (hid_sel),
        .busy       (busy),
        .done       (done),
        .acc0       (acc_v[0]),
        .acc1       (acc_v[1]),
        .acc2       (acc_v[2]),
        .acc3       (acc_v[3]),
        .acc4       (acc_v[4]),
        .acc5       (acc_v[5]),
        .acc6       (acc_v[6]),
        .acc7       (acc_v[7]),
        .acc8       (acc_v[8]),
        .acc9       (acc_v[9])
`ifdef OUTPUT_ARGMAX_EN
        ,
        .class_idx  (class_idx)
`endif
    );

    // Weight table contents for class k at row r
    function automatic int model_w(input int mode, input int k, input int r);
        case (mode)
            0: return 1;
            1: return k - 5;
            2: return -128;
            3: return 7;
            default: return ((k * 7 + r * 13) % 31) - 15;
        endcase
    endfunction

    function automatic int model_a(input int mode, input int r);
        case (mode)
            0: return 1;
            1: return 255;
            2: return 255;
            3: return r + 1;
            default: return (r * 37 + 11) % 256;
        endcase
    endfunction

    function automatic longint exp_acc(input int mode, input int k);
        longint s = 0;
        for (int r = 0; r < N_HID; r++) s += longint'(model_w(mode, k, r)) * longint'(model_a(mode, r));
        return s;
    endfunction

    function automatic int exp_class(input int mode);
        int best = 0;
        for (int k = 1; k < N_OUT; k++) if (exp_acc(mode, k) > exp_acc(mode, best)) best = k;
        return best;
    endfunction

    always_comb begin
        hidden_act = 8'(model_a(mode_sel, int'(hid_sel)));
        for (int k = 0; k < N_OUT; k++) w_drv[k] = 8'(model_w(mode_sel, k, int'(hid_sel)));
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Phase p: 0 = start/idle cycle, 1..LAT-1 busy, LAT = done cycle
    task automatic check_phase(input int p);
        chk($sformatf("busy@%0d", p), longint'(busy), longint'(p >= 1 && p <= LAT - 1));
        chk($sformatf("done@%0d", p), longint'(done), longint'(p == LAT));
        chk($sformatf("hid_sel@%0d", p), longint'(hid_sel), (p >= 1 && p <= N_HID) ? longint'(p - 1) : 0);
    endtask

    task automatic check_scores(input int mode);
        for (int k = 0; k < N_OUT; k++)
            chk($sformatf("m%0d_acc%0d", mode, k), longint'(acc_v[k]), exp_acc(mode, k));
`ifdef OUTPUT_ARGMAX_EN
        chk($sformatf("m%0d_class", mode), longint'(class_idx), longint'(exp_class(mode)));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hid_sel"}, longint'(hid_sel), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        for (int k = 0; k < N_OUT; k++) chk($sformatf("%s_acc%0d", tag, k), longint'(acc_v[k]), 0);
        chk({tag, "_class"}, longint'(class_idx), 0);
    endtask

    task automatic run_pass(input int mode);
        @(negedge clk);
        mode_sel = mode;
        start = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_phase(c);
            if (c == LAT) check_scores(mode);
        end
    endtask

    initial begin
        logic [23:0] raw;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // All-ones: every score is the hidden-neuron count
        run_pass(0);
        chk("pin_acc3_eq_20", longint'(acc_v[3]), 20);

        // Weights k-5 at activation 255
        run_pass(1);
        chk("pin_acc0", longint'(acc_v[0]), -25500);
        chk("pin_acc9", longint'(acc_v[9]), 20400);
`ifdef OUTPUT_ARGMAX_EN
        chk("pin_class9", longint'(class_idx), 9);
`endif

        // Most negative weights: largest magnitude score without wrap
        run_pass(2);
        raw = acc_v[5];
        chk("pin_acc5_hex", longint'(raw), longint'(24'hF60A00));

        // All scores tie
        run_pass(3);
`ifdef OUTPUT_ARGMAX_EN
        chk("pin_tie_class0", longint'(class_idx), 0);
`endif

        run_pass(4);

        // Reset in the middle of a pass
        @(negedge clk);
        mode_sel = 4;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_phase(c);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(negedge clk);
            chk("after_rst_done", longint'(done), 0);
            chk("after_rst_busy", longint'(busy), 0);
        end
        run_pass(4);

        // Start held high: back-to-back passes, one IDLE cycle between them
        @(negedge clk);
        mode_sel = 1;
        start = 1'b1;
        for (int c = 1; c <= 2 * LAT + 1; c++) begin
            @(negedge clk);
            check_phase((c <= LAT) ? c : c - (LAT + 1));
            if (c == LAT) begin
                check_scores(1);
                mode_sel = 4;
            end
            if (c == LAT + 2)
                for (int k = 0; k < N_OUT; k++) chk($sformatf("held_clear_acc%0d", k), longint'(acc_v[k]), 0);
            if (c == 2 * LAT + 1) begin
                check_scores(4);
                start = 1'b0;
            end
        end
        @(negedge clk);
        check_phase(0);
        @(negedge clk);
        check_phase(0);
        check_scores(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
